// File: rtl/caravel_io_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// caravel_io_ctrl_pkg
// Shared definitions for the Caravel user pad controller:
//   - byte offsets of the register window (L = pads 0..31, H = pads 32..63)
//   - bus FSM state encoding
//   - MAX_IO, the widest pad vector the register file supports
//   - byte_mask(), expanding Wishbone byte selects into a 32-bit bit mask
// -----------------------------------------------------------------------------
package caravel_io_ctrl_pkg;

    localparam int MAX_IO = 64;

    // Byte offsets inside the 256 B window. Each register is an L/H pair, so
    // adr[7:3] selects the register and adr[2] selects the half.
    localparam logic [7:0] OFF_SEL_L     = 8'h00;
    localparam logic [7:0] OFF_SEL_H     = 8'h04;
    localparam logic [7:0] OFF_OUT_L     = 8'h08;
    localparam logic [7:0] OFF_OUT_H     = 8'h0C;
    localparam logic [7:0] OFF_OEB_L     = 8'h10;
    localparam logic [7:0] OFF_OEB_H     = 8'h14;
    localparam logic [7:0] OFF_IN_L      = 8'h18;
    localparam logic [7:0] OFF_IN_H      = 8'h1C;
    localparam logic [7:0] OFF_IRQ_EN_L  = 8'h20;
    localparam logic [7:0] OFF_IRQ_EN_H  = 8'h24;
    localparam logic [7:0] OFF_IRQ_STS_L = 8'h28;
    localparam logic [7:0] OFF_IRQ_STS_H = 8'h2C;
    localparam logic [7:0] OFF_IRQ_POL_L = 8'h30;
    localparam logic [7:0] OFF_IRQ_POL_H = 8'h34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/caravel_io_ctrl_edge_det.sv
// -----------------------------------------------------------------------------
// io_ctrl_edge_det
// Brings asynchronous pad inputs into the clock domain with a two-flop
// synchroniser, keeps one history flop and flags edges.
//   i_clk, i_rst_n   clock, async active-low reset
//   i_pad  [WIDTH]   raw pad inputs
//   o_sync [WIDTH]   synchronised pad value
//   o_rise [WIDTH]   one-cycle pulse on a 0->1 transition
//   o_fall [WIDTH]   one-cycle pulse on a 1->0 transition
// A pad change reaches o_sync after two edges; the edge pulse is present
// during the following cycle, so a status flop set from it updates on the
// third edge.
// -----------------------------------------------------------------------------
module io_ctrl_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_pad,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_hist;

    // Flops clear to 0, so a pad already high when reset is released is seen
    // as a rising edge once it has passed the synchroniser.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_hist <= '0;
        end else begin
            r_meta <= i_pad;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_hist;
    assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/caravel_io_ctrl.sv
// -----------------------------------------------------------------------------
// caravel_io_ctrl
// Wishbone-slave pad controller between the Caravel management port and the
// user pads. Each pad is either passed through from the core or driven from
// the OUT/OEB registers; pad inputs are synchronised and rising edges (or
// per-pad falling edges, see below) latch into a W1C status register that
// feeds user_irq[0].
//
// Parameters: NUM_IO (1..64), NUM_IRQ (>=1), BASE_ADDR (256 B aligned),
//             WAIT_STATES (0..7, extra cycles before ack).
// Ports:
//   wb_clk_i, wb_rst_ni        clock, async active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i, wbs_dat_o, wbs_ack_o   Wishbone slave
//   core_out_i, core_oeb_i     core-side pad drive
//   core_irq_i                 core interrupts
//   io_in, io_out, io_oeb      pads (io_oeb active-low)
//   user_irq                   interrupts to the management SoC
//
// Optional build macro IO_CTRL_EDGE_POL_EN: adds IRQ_POL at 0x30/0x34
// (1 = falling edge for that pad). Without it, only rising edges are
// detected and 0x30/0x34 read as unmapped.
// -----------------------------------------------------------------------------
module caravel_io_ctrl
    import caravel_io_ctrl_pkg::*;
#(
    parameter int          NUM_IO      = 38,
    parameter int          NUM_IRQ     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic [31:0]        wbs_dat_o,
    output logic               wbs_ack_o,
    input  logic [NUM_IO-1:0]  core_out_i,
    input  logic [NUM_IO-1:0]  core_oeb_i,
    input  logic [NUM_IRQ-1:0] core_irq_i,
    input  logic [NUM_IO-1:0]  io_in,
    output logic [NUM_IO-1:0]  io_out,
    output logic [NUM_IO-1:0]  io_oeb,
    output logic [NUM_IRQ-1:0] user_irq
);

    // Bits at or above NUM_IO are held at 0 in every register.
    localparam logic [MAX_IO-1:0] IO_MASK =
        (NUM_IO >= MAX_IO) ? {MAX_IO{1'b1}} : ((64'd1 << NUM_IO) - 64'd1);
    localparam logic [2:0] WS_LAST =
        (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e            r_state;
    logic [2:0]        r_cnt;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_irq0;

    logic [MAX_IO-1:0] r_sel;
    logic [MAX_IO-1:0] r_out;
    logic [MAX_IO-1:0] r_oeb;
    logic [MAX_IO-1:0] r_irq_en;
    logic [MAX_IO-1:0] r_irq_sts;
`ifdef IO_CTRL_EDGE_POL_EN
    logic [MAX_IO-1:0] r_irq_pol;
`endif

    logic              w_req;
    logic              w_hit;
    logic              w_go_ack;
    logic              w_wr;
    logic [4:0]        w_grp;
    logic [MAX_IO-1:0] w_wmask;
    logic [MAX_IO-1:0] w_wdata;
    logic [MAX_IO-1:0] w_clr;
    logic [MAX_IO-1:0] w_sync;
    logic [MAX_IO-1:0] w_rise;
    logic [MAX_IO-1:0] w_fall;
    logic [MAX_IO-1:0] w_edge;
    logic [MAX_IO-1:0] w_sts_next;
    logic [MAX_IO-1:0] w_rd64;
    logic [31:0]       w_rd32;

    logic [NUM_IO-1:0] w_sync_io;
    logic [NUM_IO-1:0] w_rise_io;
    logic [NUM_IO-1:0] w_fall_io;

    io_ctrl_edge_det #(
        .WIDTH (NUM_IO)
    ) u_edge_det (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_pad   (io_in),
        .o_sync  (w_sync_io),
        .o_rise  (w_rise_io),
        .o_fall  (w_fall_io)
    );

    // ---------------------------------------------------------------- decode
    assign w_req = wbs_cyc_i & wbs_stb_i;
    assign w_hit = w_req & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_grp = wbs_adr_i[7:3];

    // The cycle in which the FSM moves into ACK: write data and read data
    // are both taken on the edge that raises ack.
    assign w_go_ack = ((r_state == IDLE) && w_hit && (WAIT_STATES == 0)) ||
                      ((r_state == WAIT) && w_req && (r_cnt == WS_LAST));
    assign w_wr     = w_go_ack & wbs_we_i;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_wmask = '0;
        w_wdata = {wbs_dat_i, wbs_dat_i};
        if (wbs_adr_i[2]) w_wmask[63:32] = byte_mask(wbs_sel_i);
        else              w_wmask[31:0]  = byte_mask(wbs_sel_i);
        w_wmask = w_wmask & IO_MASK;

        w_sync = '0;
        w_rise = '0;
        w_fall = '0;
        w_sync[NUM_IO-1:0] = w_sync_io;
        w_rise[NUM_IO-1:0] = w_rise_io;
        w_fall[NUM_IO-1:0] = w_fall_io;

`ifdef IO_CTRL_EDGE_POL_EN
        w_edge = (w_rise & ~r_irq_pol) | (w_fall & r_irq_pol);
`else
        w_edge = w_rise;
`endif

        w_clr = '0;
        if (w_wr && (w_grp == OFF_IRQ_STS_L[7:3])) w_clr = w_wdata & w_wmask;
        // A new edge in the same cycle as its W1C clear keeps the bit set.
        w_sts_next = (r_irq_sts & ~w_clr) | w_edge;

        w_rd64 = '0;
        case (w_grp)
            OFF_SEL_L[7:3]:     w_rd64 = r_sel;
            OFF_OUT_L[7:3]:     w_rd64 = r_out;
            OFF_OEB_L[7:3]:     w_rd64 = r_oeb;
            OFF_IN_L[7:3]:      w_rd64 = w_sync;
            OFF_IRQ_EN_L[7:3]:  w_rd64 = r_irq_en;
            OFF_IRQ_STS_L[7:3]: w_rd64 = r_irq_sts;
`ifdef IO_CTRL_EDGE_POL_EN
            OFF_IRQ_POL_L[7:3]: w_rd64 = r_irq_pol;
`endif
            default:            w_rd64 = '0;
        endcase
        w_rd32 = wbs_adr_i[2] ? w_rd64[63:32] : w_rd64[31:0];
    end

    // -------------------------------------------------------------- bus FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ack <= 1'b0;
            r_dat <= '0;
            if (w_go_ack) begin
                r_ack <= 1'b1;
                r_dat <= wbs_we_i ? 32'd0 : w_rd32;
            end
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_cnt   <= 3'd0;
                        r_state <= (WAIT_STATES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!w_req)                r_state <= IDLE;
                    else if (r_cnt == WS_LAST) r_state <= ACK;
                    else                       r_cnt   <= r_cnt + 3'd1;
                end
                ACK:     r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;

    // --------------------------------------------------------- register file
    function automatic logic [MAX_IO-1:0] merge(input logic [MAX_IO-1:0] old_v,
                                                input logic [MAX_IO-1:0] mask,
                                                input logic [MAX_IO-1:0] data);
        return (old_v & ~mask) | (data & mask);
    endfunction

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sel     <= '0;
            r_out     <= '0;
            r_oeb     <= IO_MASK;   // pads not yet configured stay tristated
            r_irq_en  <= '0;
            r_irq_sts <= '0;
            r_irq0    <= 1'b0;
        end else begin
            if (w_wr && (w_grp == OFF_SEL_L[7:3]))    r_sel    <= merge(r_sel,    w_wmask, w_wdata);
            if (w_wr && (w_grp == OFF_OUT_L[7:3]))    r_out    <= merge(r_out,    w_wmask, w_wdata);
            if (w_wr && (w_grp == OFF_OEB_L[7:3]))    r_oeb    <= merge(r_oeb,    w_wmask, w_wdata);
            if (w_wr && (w_grp == OFF_IRQ_EN_L[7:3])) r_irq_en <= merge(r_irq_en, w_wmask, w_wdata);
            r_irq_sts <= w_sts_next;
            r_irq0    <= core_irq_i[0] | (|(r_irq_sts & r_irq_en));
        end
    end

`ifdef IO_CTRL_EDGE_POL_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_irq_pol <= '0;
        end else if (w_wr && (w_grp == OFF_IRQ_POL_L[7:3])) begin
            r_irq_pol <= merge(r_irq_pol, w_wmask, w_wdata);
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, wbs_adr_i[1:0]};
`else
    logic w_unused;
    assign w_unused = &{1'b0, wbs_adr_i[1:0], w_fall};
`endif

    // -------------------------------------------------------------- pad mux
    assign io_out = (r_sel[NUM_IO-1:0] & r_out[NUM_IO-1:0]) | (~r_sel[NUM_IO-1:0] & core_out_i);
    assign io_oeb = (r_sel[NUM_IO-1:0] & r_oeb[NUM_IO-1:0]) | (~r_sel[NUM_IO-1:0] & core_oeb_i);

    // ------------------------------------------------------------------ IRQ
    generate
        if (NUM_IRQ > 1) begin : g_irq_multi
            assign user_irq = {core_irq_i[NUM_IRQ-1:1], r_irq0};
        end else begin : g_irq_single
            assign user_irq = r_irq0;
        end
    endgenerate

endmodule

// File: tb/tb_caravel_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_caravel_io_ctrl
// Directed bench for caravel_io_ctrl (NUM_IO=38, NUM_IRQ=3, WAIT_STATES=3).
// Bus tasks push the expected read data into a scoreboard queue; a monitor
// pops and compares whenever the DUT acks. Pad, IRQ and timing checks are
// made directly in the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_caravel_io_ctrl;

    localparam int          NUM_IO  = 38;
    localparam int          NUM_IRQ = 3;
    localparam int          WS      = 3;
    localparam logic [31:0] BASE    = 32'h3000_0000;

    logic               clk;
    logic               rst_n;
    logic               cyc, stb, we;
    logic [3:0]         sel;
    logic [31:0]        adr, dat_w;
    logic [31:0]        dat_r;
    logic               ack;
    logic [NUM_IO-1:0]  core_out, core_oeb, io_in, io_out, io_oeb;
    logic [NUM_IRQ-1:0] core_irq, user_irq;

    caravel_io_ctrl #(
        .NUM_IO      (NUM_IO),
        .NUM_IRQ     (NUM_IRQ),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_dat_o  (dat_r),
        .wbs_ack_o  (ack),
        .core_out_i (core_out),
        .core_oeb_i (core_oeb),
        .core_irq_i (core_irq),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .user_irq   (user_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack consumes one pending request.
    always @(negedge clk) begin
        sb_t e;
        if (ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: ack=1 with no pending request");
            end else begin
                e = sb_q.pop_front();
                if (e.is_rd) check(e.name, dat_r, e.exp);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the number of falling edges seen up to and including the one
    // at which ack is high, or -1 after 20 edges without ack.
    task automatic wait_ack(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0 && sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    // One complete transfer. Request is driven 1 time unit after a rising
    // edge; an ack WS+1 cycles later is seen at the (WS+2)-th falling edge.
    task automatic wb_xfer(input logic we_v, input logic [7:0] off, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp, input string name);
        int n;
        sb_q.push_back('{~we_v, exp, name});
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = we_v; adr = BASE | {24'd0, off}; dat_w = d; sel = s;
        wait_ack(n);
        check({name, "_latency"}, 64'(n - 1), 64'(WS + 1));
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check({name, "_ack_pulse"}, {63'd0, ack}, 64'd0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        wb_xfer(1'b1, off, d, 4'hF, 32'd0, "wr");
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
        wb_xfer(1'b0, off, 32'd0, 4'hF, exp, name);
    endtask

    initial begin
        int n1, n2, n_ack;
        logic [31:0] dat_or;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_w = '0; core_irq = '0; io_in = '0;
        core_out = 38'h2A_C3C3_5A5A;
        core_oeb = 38'h15_A5A5_3C3C;

        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_ack",      {63'd0, ack},      64'd0);
        check("rst_dat",      {32'd0, dat_r},    64'd0);
        check("rst_user_irq", {61'd0, user_irq}, 64'd0);
        check("rst_io_out",   {26'd0, io_out},   {26'd0, 38'h2A_C3C3_5A5A});
        check("rst_io_oeb",   {26'd0, io_oeb},   {26'd0, 38'h15_A5A5_3C3C});
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(2);

        rd(8'h10, 32'hFFFF_FFFF, "oeb_l_reset");
        rd(8'h14, 32'h0000_003F, "oeb_h_reset");
        rd(8'h00, 32'h0000_0000, "sel_l_reset");

        // ---- pad 0 taken over by the registers, pad 1 stays on the core
        core_out = '0;
        core_oeb = '1;
        wr(8'h00, 32'h0000_0001);
        wr(8'h08, 32'h0000_0001);
        wr(8'h10, 32'hFFFF_FFFE);
        // One cycle after the last ack
        check("pad0_out", {62'd0, io_out[1:0]}, 64'd1);
        check("pad0_oeb", {62'd0, io_oeb[1:0]}, 64'd2);
        core_out[1] = 1'b1;
        core_oeb[1] = 1'b0;
        #1;
        check("pad1_core_out", {62'd0, io_out[1:0]}, 64'd3);
        check("pad1_core_oeb", {62'd0, io_oeb[1:0]}, 64'd0);

        // ---- high half: only pads 32..37 exist
        wr(8'h04, 32'hFFFF_FFFF);
        rd(8'h04, 32'h0000_003F, "sel_h_masked");
        core_out[37:32] = 6'h3F;
        #1;
        check("pad_h_reg_out", {58'd0, io_out[37:32]}, 64'd0);
        wr(8'h04, 32'h0000_0000);
        check("pad_h_core_out", {58'd0, io_out[37:32]}, 64'h3F);

        // ---- byte-lane write
        wr(8'h00, 32'h0000_0000);
        wb_xfer(1'b1, 8'h00, 32'hFFFF_FFFF, 4'b0010, 32'd0, "wr_byte1");
        rd(8'h00, 32'h0000_FF00, "sel_l_byte1");
        wr(8'h00, 32'h0000_0000);

        // ---- back-to-back with stb held: ACK, DONE, IDLE, 3x WAIT, ACK
        sb_q.push_back('{1'b1, 32'h0000_003F, "b2b_rd1"});
        sb_q.push_back('{1'b1, 32'h0000_003F, "b2b_rd2"});
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE | 32'h14;
        wait_ack(n1);
        check("b2b_first_latency", 64'(n1 - 1), 64'(WS + 1));
        wait_ack(n2);
        check("b2b_ack_gap", 64'(n2), 64'(WS + 3));
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        cycles(3);

        // ---- address outside the window
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100;
        n_ack = 0;
        dat_or = '0;
        repeat (20) begin
            @(negedge clk);
            if (ack === 1'b1) n_ack++;
            dat_or = dat_or | dat_r;
        end
        check("miss_no_ack", 64'(n_ack), 64'd0);
        check("miss_dat_zero", {32'd0, dat_or}, 64'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        cycles(2);

        // ---- unmapped offset and read-only IN
        wr(8'h3C, 32'hFFFF_FFFF);
        rd(8'h3C, 32'h0000_0000, "unmapped_3c");
        wr(8'h18, 32'hFFFF_FFFF);
        rd(8'h18, 32'h0000_0000, "in_l_ro");

        // ---- input sync and status, IRQ_EN still 0
        io_in = 38'h20_0000_0081;
        cycles(5);
        rd(8'h18, 32'h0000_0081, "in_l");
        rd(8'h1C, 32'h0000_0020, "in_h");
        rd(8'h28, 32'h0000_0081, "sts_l_noen");
        rd(8'h2C, 32'h0000_0020, "sts_h_noen");
        check("irq_masked", {63'd0, user_irq[0]}, 64'd0);
        wr(8'h28, 32'hFFFF_FFFF);
        wr(8'h2C, 32'hFFFF_FFFF);
        rd(8'h28, 32'h0000_0000, "sts_l_cleared");
        rd(8'h2C, 32'h0000_0000, "sts_h_cleared");
        io_in = '0;
        cycles(5);
        rd(8'h28, 32'h0000_0000, "sts_l_fall_ignored");

        // ---- enabled interrupt on pad 2
        wr(8'h20, 32'h0000_0004);
        io_in[2] = 1'b1;
        cycles(5);
        rd(8'h28, 32'h0000_0004, "sts_l_pad2");
        check("user_irq0_set", {63'd0, user_irq[0]}, 64'd1);
        wr(8'h28, 32'h0000_0004);
        cycles(2);
        check("user_irq0_clr", {63'd0, user_irq[0]}, 64'd0);
        rd(8'h28, 32'h0000_0000, "sts_l_w1c");

        // ---- core IRQs
        core_irq = 3'b110;
        #1;
        check("core_irq_pass", {61'd0, user_irq}, 64'h6);
        core_irq = 3'b001;
        cycles(2);
        check("core_irq0_reg", {61'd0, user_irq}, 64'h1);
        core_irq = '0;
        cycles(2);

        // ---- W1C in the same cycle the new edge sets the bit: set wins
        io_in[2] = 1'b0;
        cycles(5);
        fork
            wr(8'h28, 32'h0000_0004);
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                io_in[2] = 1'b1;
            end
        join
        rd(8'h28, 32'h0000_0004, "sts_set_wins");
        check("user_irq0_set_wins", {63'd0, user_irq[0]}, 64'd1);
        wr(8'h28, 32'h0000_0004);

`ifdef IO_CTRL_EDGE_POL_EN
        // ---- falling-edge polarity on pad 5
        wr(8'h30, 32'h0000_0020);
        rd(8'h30, 32'h0000_0020, "pol_l");
        io_in[5] = 1'b1;
        cycles(5);
        rd(8'h28, 32'h0000_0000, "pol_rise_ignored");
        io_in[5] = 1'b0;
        cycles(5);
        rd(8'h28, 32'h0000_0020, "pol_fall_sets");
`else
        wr(8'h30, 32'hFFFF_FFFF);
        rd(8'h30, 32'h0000_0000, "pol_unmapped");
`endif

        // ---- reset while ack is high
        sb_q.push_back('{1'b1, 32'h0000_003F, "rst_mid_rd"});
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE | 32'h14;
        wait_ack(n1);
        check("rst_mid_latency", 64'(n1 - 1), 64'(WS + 1));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", {63'd0, ack}, 64'd0);
        check("rst_mid_dat", {32'd0, dat_r}, 64'd0);
        cyc = 1'b0; stb = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        rd(8'h10, 32'hFFFF_FFFF, "oeb_l_after_rst");
        rd(8'h00, 32'h0000_0000, "sel_l_after_rst");

        cycles(2);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
